// File: rtl/sigmoid_inv_32bit.sv
// Iterative inverse of the piecewise-quadratic sigmoid: y (Q16.16) -> x (Q16.16) via a 17-bit restoring sqrt.
// Build option: define SIGINV_ROUND_EN to round the root to nearest instead of truncating.
`timescale 1ns/1ps
module sigmoid_inv_32bit #(
  parameter int ROOT_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] x,
  output logic        range_err
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ROOT, S_POST} state_t;

  state_t                   r_state, w_next;
  logic [31:0]              r_y;
  logic                     r_neg, r_err;
  logic [2*ROOT_BITS-1:0]   r_rad, r_rem;
  logic [ROOT_BITS-1:0]     r_root;
  logic [4:0]               r_cnt;

  logic [ROOT_BITS:0]       w_clamp;
  logic [ROOT_BITS-1:0]     w_yc;
  logic                     w_neg;
  logic [15:0]              w_d;
  logic [ROOT_BITS-1:0]     w_t;
  logic [2*ROOT_BITS+1:0]   w_rem_sh;
  logic [2*ROOT_BITS-1:0]   w_trial;
  logic                     w_ge;
  logic [2*ROOT_BITS-1:0]   w_diff;
  logic [ROOT_BITS-1:0]     w_root_fin;
  logic [ROOT_BITS-1:0]     w_m;
  logic [31:0]              w_mag;

  // Saturate the operand into [0, 1.0]; returns {err, clamped value}.
  function automatic logic [ROOT_BITS:0] clamp_y(input logic [31:0] v);
    if (v[31])
      return {1'b1, 17'h00000};
    else if (v > 32'h0001_0000)
      return {1'b1, 17'h10000};
    else
      return {1'b0, v[ROOT_BITS-1:0]};
  endfunction

  always_comb begin
    w_clamp = clamp_y(r_y);
    w_yc    = w_clamp[ROOT_BITS-1:0];
    w_neg   = (w_yc < 17'h08000);
    // For y >= 0.5 the distance to 1.0 is at most 0.5, so 16 bits suffice.
    w_d     = 16'(17'h10000 - w_yc);
    w_t     = w_neg ? {w_yc[15:0], 1'b0} : {w_d, 1'b0};
  end

  always_comb begin
    w_rem_sh = {r_rem, r_rad[2*ROOT_BITS-1 -: 2]};
    w_trial  = {{(ROOT_BITS-2){1'b0}}, r_root, 2'b01};
    w_ge     = (w_rem_sh >= {2'b00, w_trial});
    w_diff   = w_rem_sh[2*ROOT_BITS-1:0] - w_trial;
  end

  always_comb begin
`ifdef SIGINV_ROUND_EN
    // Remainder above r means sqrt(R) lies past r + 0.5.
    w_root_fin = (r_rem > {{ROOT_BITS{1'b0}}, r_root}) ? r_root + 1'b1 : r_root;
`else
    w_root_fin = r_root;
`endif
    w_m   = 17'h10000 - w_root_fin;
    w_mag = {{(32-ROOT_BITS-2){1'b0}}, w_m, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_PREP;
      S_PREP:  w_next = S_ROOT;
      S_ROOT:  if (r_cnt == 5'(ROOT_BITS-1)) w_next = S_POST;
      S_POST:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
      r_rad     <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      range_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_y  <= y;
            busy <= 1'b1;
          end
        end
        S_PREP: begin
          r_neg  <= w_neg;
          r_err  <= w_clamp[ROOT_BITS];
          r_rad  <= {1'b0, w_t, 16'h0000};
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= '0;
        end
        // One restoring step per cycle, consuming two radicand bits MSB first.
        S_ROOT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_ge ? w_diff : w_rem_sh[2*ROOT_BITS-1:0];
          r_root <= {r_root[ROOT_BITS-2:0], w_ge};
          r_cnt  <= r_cnt + 5'd1;
        end
        S_POST: begin
          x         <= r_neg ? (32'd0 - w_mag) : w_mag;
          range_err <= r_err;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_inv_32bit.sv
// Self-checking bench for sigmoid_inv_32bit: cycle-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_sigmoid_inv_32bit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] y;
  logic        busy, done, range_err;
  logic [31:0] x;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sigmoid_inv_32bit #(.ROOT_BITS(17)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .busy(busy), .done(done), .x(x), .range_err(range_err)
  );

  // Returns {range_err, x} straight from the inverse formula.
  function automatic logic [32:0] model(input logic [31:0] v);
    longint yc, t, rr, r, mag, xv;
    bit err, neg;
    err = 0;
    if (v[31]) begin yc = 0; err = 1; end
    else if (v > 32'h10000) begin yc = 65536; err = 1; end
    else yc = longint'(v);
    neg = (yc < 32768);
    t   = neg ? 2 * yc : 2 * (65536 - yc);
    rr  = t * 65536;
    r   = longint'($sqrt(real'(rr)));
    while (r * r > rr) r--;
    while ((r + 1) * (r + 1) <= rr) r++;
`ifdef SIGINV_ROUND_EN
    if (rr - r * r > r) r++;
`endif
    mag = (65536 - r) * 4;
    xv  = neg ? -mag : mag;
    return {err, xv[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference timing: accepted start at edge k -> done visible after edge k+19.
  int          cyc = 0;
  int          due = 0;
  bit          armed = 0, pend = 0;
  logic [31:0] cap_y;
  logic        m_busy, m_done, m_err;
  logic [31:0] m_x;
  logic [32:0] m_res;

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("x", x, m_x);
      chk("range_err", {31'b0, range_err}, {31'b0, m_err});
    end
    if (rst) begin
      pend = 0; m_busy = 0; m_done = 0; m_x = 0; m_err = 0; armed = 1;
    end else begin
      m_done = 0;
      if (pend && (cyc + 1 == due)) begin
        m_res  = model(cap_y);
        m_x    = m_res[31:0];
        m_err  = m_res[32];
        m_done = 1;
        m_busy = 0;
        pend   = 0;
      end else if (!pend && start) begin
        pend   = 1;
        due    = cyc + 1 + 19;
        cap_y  = y;
        m_busy = 1;
      end
    end
    cyc++;
  end

  task automatic wait_done(inout int n, output bit got);
    got = 0;
    while (!got && n < 60) begin
      @(posedge clk); n++; #1;
      if (done) got = 1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
    end
  endtask

  task automatic do_op(input logic [31:0] v, input logic [31:0] ex, input logic ee);
    int n; bit got;
    @(posedge clk); #1 start = 1; y = v;
    @(posedge clk); #1 start = 0;
    n = 0;
    wait_done(n, got);
    if (got) begin
      chk("latency", n, 19);
      chk("op_x", x, ex);
      chk("op_err", {31'b0, range_err}, {31'b0, ee});
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, d1, d2, t, cnt;
    bit got;
    logic [32:0] r;
    logic [31:0] v;
    rst = 1; start = 0; y = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("reset_x", x, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);

    do_op(32'h0000_8000, 32'h0000_0000, 1'b0);
    do_op(32'h0001_0000, 32'h0004_0000, 1'b0);
    do_op(32'h0000_0000, 32'hFFFC_0000, 1'b0);
`ifdef SIGINV_ROUND_EN
    do_op(32'h0000_4000, 32'hFFFE_D414, 1'b0);
    do_op(32'h0000_C000, 32'h0001_2BEC, 1'b0);
`else
    do_op(32'h0000_4000, 32'hFFFE_D410, 1'b0);
    do_op(32'h0000_C000, 32'h0001_2BF0, 1'b0);
`endif
    do_op(32'h0002_0000, 32'h0004_0000, 1'b1);
    do_op(32'hFFFF_0000, 32'hFFFC_0000, 1'b1);

    // Back-to-back with start held high.
    @(posedge clk); #1 start = 1; y = 32'h0000_8000;
    @(posedge clk); #1 y = 32'h0001_0000;
    t = 1; d1 = -1; d2 = -1;
    while (t < 80 && d2 < 0) begin
      @(posedge clk); t++; #1;
      if (done) begin
        if (d1 < 0) d1 = t; else d2 = t;
      end
    end
    start = 0;
    chk("b2b_first", d1, 20);
    chk("b2b_gap", d2 - d1, 20);
    chk("b2b_x", x, 32'h0004_0000);
    @(posedge clk); #1;

    // Start pulse during ROOT must be ignored.
    @(posedge clk); #1 start = 1; y = 32'h0000_8000;
    @(posedge clk); #1 start = 0;
    n = 0;
    repeat (6) begin @(posedge clk); n++; end
    #1 start = 1; y = 32'h0001_0000;
    @(posedge clk); n++; #1 start = 0;
    wait_done(n, got);
    if (got) begin
      chk("ignore_latency", n, 19);
      chk("ignore_x", x, 32'h0000_0000);
    end
    count_done(25, cnt);
    chk("ignore_no_extra", cnt, 0);

    // Reset in the middle of an operation.
    @(posedge clk); #1 start = 1; y = 32'h0000_C000;
    @(posedge clk); #1 start = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_x", x, 32'h0);
    count_done(30, cnt);
    chk("midrst_no_done", cnt, 0);
    do_op(32'h0001_0000, 32'h0004_0000, 1'b0);

    // Reset beats a simultaneous start.
    @(posedge clk); #1 rst = 1; start = 1; y = 32'h0000_4000;
    @(posedge clk); #1 rst = 0; start = 0;
    chk("rststart_busy", {31'b0, busy}, 32'h0);
    count_done(25, cnt);
    chk("rststart_no_done", cnt, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) v = $urandom;
      else v = $urandom_range(0, 32'h10000);
      r = model(v);
      do_op(v, r[31:0], r[32]);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
